fifo_wr_arbiter: RTL and testbench

//   Packet-aware round-robin arbiter that shares the single write port of the SRAM-backed fifo among
//   NUM_REQ valid/ready requesters. Once granted, a requester owns the port until its last beat or

---
 rtl/fifo_wr_arbiter_if.sv | 30 +++
 rtl/fifo_wr_arbiter.sv | 115 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Bundle between the write requesters, the arbiter and the fifo write port.
// The master side drives the requests and w_rdy; the slave side is the arbiter itself.
interface fifo_wr_arbiter_if #(
  parameter int WIDTH   = 45,
  parameter int NUM_REQ = 4
) ();
  localparam int SW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_en;
  logic [NUM_REQ-1:0]       req_vld;
  logic [NUM_REQ-1:0]       req_last;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_rdy;
  logic                     w_vld;
  logic                     w_rdy;
  logic [WIDTH-1:0]         w_data;
  logic [SW-1:0]            out_src;
  logic                     out_last;
  logic                     busy;

  modport master (
    output req_en, req_vld, req_last, req_data, w_rdy,
    input  req_rdy, w_vld, w_data, out_src, out_last, busy
  );

  modport slave (
    input  req_en, req_vld, req_last, req_data, w_rdy,
    output req_rdy, w_vld, w_data, out_src, out_last, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Packet-aware round-robin arbiter sharing the fifo write port among NUM_REQ requesters.
// A grant lasts until the owner's last beat or MAX_BEATS beats, with one bubble per arbitration.
module fifo_wr_arbiter #(
  parameter int WIDTH     = 45,
  parameter int NUM_REQ   = 4,
  parameter int MAX_BEATS = 16
) (
  input  logic               axis_clk,
  input  logic               axi_reset_n,
  fifo_wr_arbiter_if.slave   bus
);
  localparam int SW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BEATS);
  localparam logic [SW-1:0] LAST_GRANT_RST = SW'(NUM_REQ - 1);
  localparam logic [CW-1:0] BEAT_LIMIT     = CW'(MAX_BEATS - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [SW-1:0]    grant_q, grant_d;
  logic [SW-1:0]    last_grant_q, last_grant_d;
  logic [CW-1:0]    beat_cnt_q, beat_cnt_d;

  logic [WIDTH-1:0]   data_arr [NUM_REQ];
  logic [NUM_REQ-1:0] cand;
  logic               at_limit;
  logic               beat;

  // First candidate after the previous owner, wrapping NUM_REQ-1 -> 0.
  function automatic logic [SW-1:0] rr_pick(input logic [NUM_REQ-1:0] c,
                                            input logic [SW-1:0]      last);
    logic [SW-1:0] pick;
    logic [SW-1:0] idx;
    logic          found;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = SW'((int'(last) + k) % NUM_REQ);
      if (!found && c[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign data_arr[i] = bus.req_data[i*WIDTH +: WIDTH];
  end

  assign cand     = bus.req_vld & bus.req_en;
  assign at_limit = (beat_cnt_q == BEAT_LIMIT);
  assign beat     = bus.w_vld & bus.w_rdy;

  // Owner's beat path is purely combinational; reset masks the handshake immediately.
  always_comb begin
    bus.req_rdy  = '0;
    bus.w_vld    = 1'b0;
    bus.w_data   = '0;
    bus.out_last = 1'b0;
    bus.busy     = 1'b0;
    bus.out_src  = grant_q;
    if (state_q == BUSY) begin
      bus.busy     = 1'b1;
      bus.w_data   = data_arr[grant_q];
      bus.out_last = bus.req_last[grant_q] | at_limit;
      if (axi_reset_n) begin
        bus.w_vld            = bus.req_vld[grant_q];
        bus.req_rdy[grant_q] = bus.w_rdy;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (cand != '0) begin
          grant_d    = rr_pick(cand, last_grant_q);
          beat_cnt_d = '0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (beat) begin
          if (bus.out_last) begin
            state_d      = IDLE;
            last_grant_d = grant_q;
            beat_cnt_d   = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axis_clk) begin
    if (!axi_reset_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= LAST_GRANT_RST;
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomised bench for fifo_wr_arbiter: a transaction-level model predicts per-cycle status
// and the accepted beat stream; a monitor compares both against the DUT on the falling edge.
module tb_fifo_wr_arbiter;
  localparam int WIDTH     = 45;
  localparam int NUM_REQ   = 4;
  localparam int MAX_BEATS = 16;
  localparam int SW        = $clog2(NUM_REQ);

  typedef struct packed {
    logic               busy;
    logic [SW-1:0]      src;
    logic [NUM_REQ-1:0] rdy;
    logic               vld;
    logic               last;
    logic [WIDTH-1:0]   data;
  } status_t;

  typedef struct packed {
    logic [SW-1:0]    src;
    logic             last;
    logic [WIDTH-1:0] data;
  } beat_t;

  logic axis_clk    = 1'b0;
  logic axi_reset_n = 1'b0;
  always #5 axis_clk = ~axis_clk;

  fifo_wr_arbiter_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) bus ();

  fifo_wr_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .MAX_BEATS(MAX_BEATS)) dut (
    .axis_clk    (axis_clk),
    .axi_reset_n (axi_reset_n),
    .bus         (bus)
  );

  status_t exp_q[$];
  beat_t   beat_q[$];
  int      n_checks = 0;
  int      n_errors = 0;

  // Requester sources: current beat payload and beats left in the current packet.
  logic [WIDTH-1:0] cur  [NUM_REQ];
  int               rem  [NUM_REQ];

  // Reference model state.
  logic             m_busy;
  logic [SW-1:0]    m_own;
  logic [SW-1:0]    m_prev;
  logic [SW-1:0]    m_src;
  int               m_cnt;

  function automatic logic [WIDTH-1:0] rand_data();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[WIDTH-1:0];
  endfunction

  task automatic advance_src(input logic [SW-1:0] o);
    cur[o] = rand_data();
    rem[o] = rem[o] - 1;
    if (rem[o] == 0) rem[o] = $urandom_range(1, 20);
  endtask

  task automatic cycle(input logic rstn, input int p_vld, input int p_rdy, input int p_en);
    status_t            e;
    beat_t              b;
    logic [NUM_REQ-1:0] v, en, l;
    logic [SW-1:0]      ix, j;
    logic               wr, found;
    @(posedge axis_clk);
    #2;
    for (int i = 0; i < NUM_REQ; i++) begin
      ix     = SW'(i);
      v[ix]  = ($urandom_range(0, 99) < p_vld);
      en[ix] = ($urandom_range(0, 99) < p_en);
      l[ix]  = (rem[ix] == 1);
      bus.req_data[i*WIDTH +: WIDTH] = cur[ix];
    end
    wr           = ($urandom_range(0, 99) < p_rdy);
    axi_reset_n  = rstn;
    bus.req_vld  = v;
    bus.req_en   = en;
    bus.req_last = l;
    bus.w_rdy    = wr;

    e      = '0;
    e.src  = m_src;
    e.busy = m_busy;
    if (m_busy) begin
      e.data = cur[m_own];
      e.last = l[m_own] || (m_cnt == MAX_BEATS - 1);
      if (rstn) begin
        e.vld        = v[m_own];
        e.rdy[m_own] = wr;
      end
    end
    exp_q.push_back(e);

    if (!rstn) begin
      m_busy = 1'b0;
      m_prev = SW'(NUM_REQ - 1);
      m_src  = '0;
      m_cnt  = 0;
    end else if (!m_busy) begin
      found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
        j = SW'((int'(m_prev) + k) % NUM_REQ);
        if (!found && v[j] && en[j]) begin
          found  = 1'b1;
          m_busy = 1'b1;
          m_own  = j;
          m_src  = j;
          m_cnt  = 0;
        end
      end
    end else if (v[m_own] && wr) begin
      b.src  = m_own;
      b.last = e.last;
      b.data = cur[m_own];
      beat_q.push_back(b);
      advance_src(m_own);
      if (e.last) begin
        m_busy = 1'b0;
        m_prev = m_own;
        m_cnt  = 0;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
  endtask

  initial begin : monitor
    status_t act, e;
    beat_t   b;
    forever begin
      @(negedge axis_clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {bus.busy, bus.out_src, bus.req_rdy, bus.w_vld, bus.out_last, bus.w_data};
        n_checks++;
        if (act !== e) begin
          n_errors++;
          $display("FAIL status t=%0t got busy=%b src=%0d rdy=%b vld=%b last=%b data=%h want busy=%b src=%0d rdy=%b vld=%b last=%b data=%h",
                   $time, act.busy, act.src, act.rdy, act.vld, act.last, act.data,
                   e.busy, e.src, e.rdy, e.vld, e.last, e.data);
        end
      end
      if (bus.w_vld === 1'b1 && bus.w_rdy === 1'b1) begin
        n_checks++;
        if (beat_q.size() == 0) begin
          n_errors++;
          $display("FAIL beat t=%0t got unexpected beat src=%0d data=%h want no beat",
                   $time, bus.out_src, bus.w_data);
        end else begin
          b = beat_q.pop_front();
          if (bus.out_src !== b.src || bus.w_data !== b.data || bus.out_last !== b.last) begin
            n_errors++;
            $display("FAIL beat t=%0t got src=%0d last=%b data=%h want src=%0d last=%b data=%h",
                     $time, bus.out_src, bus.out_last, bus.w_data, b.src, b.last, b.data);
          end
        end
      end
    end
  end

  initial begin : driver
    for (int i = 0; i < NUM_REQ; i++) begin
      cur[i] = rand_data();
      rem[i] = $urandom_range(1, 20);
    end
    m_busy       = 1'b0;
    m_own        = '0;
    m_prev       = SW'(NUM_REQ - 1);
    m_src        = '0;
    m_cnt        = 0;
    bus.req_en   = '0;
    bus.req_vld  = '0;
    bus.req_last = '0;
    bus.req_data = '0;
    bus.w_rdy    = 1'b0;
    repeat (3) @(posedge axis_clk);

    repeat (3)   cycle(1'b0, 80, 100, 100);
    repeat (600) cycle(1'b1, 100, 100, 100);
    repeat (600) cycle(1'b1, 70, 60, 100);
    repeat (600) cycle(1'b1, 80, 70, 75);
    repeat (2)   cycle(1'b0, 90, 80, 100);
    repeat (600) cycle(1'b1, 90, 80, 100);
    repeat (5)   cycle(1'b0, 50, 50, 100);
    repeat (400) cycle(1'b1, 60, 20, 60);
    repeat (4)   cycle(1'b1, 0, 100, 100);

    @(negedge axis_clk);
    #1;
    n_checks++;
    if (beat_q.size() != 0 || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain got beats_left=%0d status_left=%0d want 0 and 0",
               beat_q.size(), exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
